slave_split_if: RTL and testbench

//  Slave-side endpoint of the per-slave split line into bus_controller's slaves[i] port.

---
 rtl/slave_split_if_pkg.sv | 30 +++
 rtl/slave_split_if_if.sv | 34 +++
 rtl/slave_split_if.sv | 126 ++++++++++++
 tb/tb_slave_split_if.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/slave_split_if_pkg.sv
// rtl/slave_split_if_pkg.sv - shared split-line types and constants
// Purpose: FSM state encoding and split-line signalling codes shared between
//          the slave split endpoint and the bus controller.
// Ports:   none (package).
package slave_split_if_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SPLIT    = 3'd1,
        DONE_DRV = 3'd2,
        WAIT_ACK = 3'd3,
        RESUME   = 3'd4
    } split_state_t;

    localparam logic SPLIT_LINE_BUSY = 1'b1;
    localparam logic SPLIT_LINE_DONE = 1'b0;

    // Controller-side view of each slave's split line.
    typedef enum logic [1:0] {
        SLAVE_FREE = 2'd0,
        SLAVE_BUSY = 2'd1,
        SLAVE_DONE = 2'd2
    } slave_split_code_t;

    // Only a solid 1 counts as an ack; X or Z on the line reads as "no ack".
    function automatic logic line_is_ack(input logic v);
        return (v === 1'b1);
    endfunction

endpackage

// File: rtl/slave_split_if_if.sv
// rtl/slave_split_if_if.sv - core-side handshake bundle for the split endpoint
// Purpose: groups the slave core <-> split endpoint handshake.
// Ports (signals):
//   split_req    core -> endpoint  start a split (sampled in IDLE)
//   core_done    core -> endpoint  result ready (level)
//   resume       endpoint -> core  1-cycle pulse, core may respond now
//   split_active endpoint -> core  split in progress
//   split_err    endpoint -> core  1-cycle pulse on ack timeout
interface slave_split_if_if;

    logic split_req;
    logic core_done;
    logic resume;
    logic split_active;
    logic split_err;

    // master: the slave core; slave: the split endpoint.
    modport master (
        output split_req,
        output core_done,
        input  resume,
        input  split_active,
        input  split_err
    );

    modport slave (
        input  split_req,
        input  core_done,
        output resume,
        output split_active,
        output split_err
    );

endinterface

// File: rtl/slave_split_if.sv
// rtl/slave_split_if.sv - slave-side split line endpoint
// Purpose: lets a slave core release the bus during a long operation by
//          driving its split line busy, then signalling done and waiting for
//          the controller's one-cycle ack before resuming.
// Ports:
//   clk        in     system clock, posedge
//   rstn       in     asynchronous active-low reset
//   split_line inout  split line to the controller, pulled down externally
//   core       slave modport of slave_split_if_if (core handshake)
module slave_split_if
    import slave_split_if_pkg::*;
#(
    parameter int MIN_SPLIT_CYC = 2,
    parameter int DONE_HOLD_CYC = 2,
    parameter int ACK_TIMEOUT   = 1023,
    parameter int CNT_W         = 10
) (
    input  logic           clk,
    input  logic           rstn,
    inout  wire            split_line,
    slave_split_if_if.slave core
);

    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] SPLIT_SAT    = CNT_W'(MIN_SPLIT_CYC);
    localparam logic [CNT_W-1:0] SPLIT_MIN_M1 = CNT_W'(MIN_SPLIT_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(DONE_HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] ACK_LAST     = CNT_W'(ACK_TIMEOUT - 1);
    localparam logic             ACK_TO_EN    = (ACK_TIMEOUT != 0);

    split_state_t     state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             drv_en_q;
    logic             drv_val_q;
    logic             resume_q;
    logic             split_active_q;
    logic             split_err_q;

    // drv_val is only ever 1 while in SPLIT, so the endpoint can never fight
    // the controller's ack, which arrives only after we have released to Z.
    assign split_line = drv_en_q ? drv_val_q : 1'bz;

    assign core.resume       = resume_q;
    assign core.split_active = split_active_q;
    assign core.split_err    = split_err_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            drv_en_q       <= 1'b0;
            drv_val_q      <= SPLIT_LINE_DONE;
            resume_q       <= 1'b0;
            split_active_q <= 1'b0;
            split_err_q    <= 1'b0;
        end else begin
            resume_q    <= 1'b0;
            split_err_q <= 1'b0;

            case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    if (core.split_req) begin
                        state_q        <= SPLIT;
                        drv_en_q       <= 1'b1;
                        drv_val_q      <= SPLIT_LINE_BUSY;
                        split_active_q <= 1'b1;
                    end
                end

                SPLIT: begin
                    // cnt counts completed busy cycles; the line has been busy
                    // for cnt+1 cycles at this edge, so cnt >= MIN-1 meets it.
                    if (core.core_done && (cnt_q >= SPLIT_MIN_M1)) begin
                        state_q   <= DONE_DRV;
                        drv_val_q <= SPLIT_LINE_DONE;
                        cnt_q     <= '0;
                    end else if (cnt_q != SPLIT_SAT) begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end

                DONE_DRV: begin
                    if (cnt_q == HOLD_LAST) begin
                        state_q  <= WAIT_ACK;
                        drv_en_q <= 1'b0;
                        cnt_q    <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end

                WAIT_ACK: begin
                    // Ack is tested first so it wins over a coincident timeout.
                    if (line_is_ack(split_line)) begin
                        state_q        <= RESUME;
                        resume_q       <= 1'b1;
                        split_active_q <= 1'b0;
                        cnt_q          <= '0;
                    end else if (ACK_TO_EN && (cnt_q == ACK_LAST)) begin
                        state_q        <= IDLE;
                        split_err_q    <= 1'b1;
                        split_active_q <= 1'b0;
                        cnt_q          <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end

                RESUME: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                end

                default: begin
                    state_q        <= IDLE;
                    cnt_q          <= '0;
                    drv_en_q       <= 1'b0;
                    drv_val_q      <= SPLIT_LINE_DONE;
                    split_active_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_slave_split_if.sv
// tb/tb_slave_split_if.sv - directed self-checking bench for slave_split_if
module tb_slave_split_if;

    logic clk    = 1'b0;
    logic rstn   = 1'b0;
    logic ack_en = 1'b0;
    wire  split_line;
    int   checks   = 0;
    int   failures = 0;

    slave_split_if_if core_if ();

    pulldown (split_line);
    assign split_line = ack_en ? 1'b1 : 1'bz;

    slave_split_if #(
        .MIN_SPLIT_CYC(2),
        .DONE_HOLD_CYC(2),
        .ACK_TIMEOUT  (8),
        .CNT_W        (10)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .split_line(split_line),
        .core      (core_if)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        core_if.split_req = 1'b0;
        core_if.core_done = 1'b0;
        ack_en = 1'b0;
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
    endtask

    // Stimulus only: walks IDLE -> SPLIT -> DONE_DRV -> WAIT_ACK (5 edges).
    task automatic enter_wait_ack();
        core_if.split_req = 1'b1;
        core_if.core_done = 1'b1;
        tick();
        core_if.split_req = 1'b0;
        tick();
        tick();
        core_if.core_done = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (core_if.split_active !== 1'b0) begin failures++; $display("FAIL reset_active got=%b exp=0", core_if.split_active); end
        checks++; if (core_if.resume !== 1'b0) begin failures++; $display("FAIL reset_resume got=%b exp=0", core_if.resume); end
        checks++; if (core_if.split_err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", core_if.split_err); end
        checks++; if (dut.drv_en_q !== 1'b0) begin failures++; $display("FAIL reset_released got=%b exp=0", dut.drv_en_q); end
        checks++; if (split_line !== 1'b0) begin failures++; $display("FAIL reset_line got=%b exp=0", split_line); end
    endtask

    task automatic test_basic();
        do_reset();
        core_if.split_req = 1'b1;
        tick();
        core_if.split_req = 1'b0;
        checks++; if (split_line !== 1'b1 || core_if.split_active !== 1'b1) begin failures++; $display("FAIL basic_start line=%b active=%b exp=1/1", split_line, core_if.split_active); end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (split_line !== 1'b1) begin failures++; $display("FAIL basic_busy[%0d] got=%b exp=1", i, split_line); end
        end
        core_if.core_done = 1'b1;
        tick();
        core_if.core_done = 1'b0;
        checks++; if (split_line !== 1'b0 || dut.drv_en_q !== 1'b1) begin failures++; $display("FAIL basic_done0 line=%b drv=%b exp=0/1", split_line, dut.drv_en_q); end
        tick();
        checks++; if (split_line !== 1'b0 || dut.drv_en_q !== 1'b1) begin failures++; $display("FAIL basic_done1 line=%b drv=%b exp=0/1", split_line, dut.drv_en_q); end
        tick();
        checks++; if (dut.drv_en_q !== 1'b0 || core_if.split_active !== 1'b1) begin failures++; $display("FAIL basic_release drv=%b active=%b exp=0/1", dut.drv_en_q, core_if.split_active); end
        tick();
        tick();
        checks++; if (core_if.resume !== 1'b0) begin failures++; $display("FAIL basic_no_early_resume got=%b exp=0", core_if.resume); end
        ack_en = 1'b1;
        #1;
        checks++; if (split_line !== 1'b1) begin failures++; $display("FAIL basic_ack_clean got=%b exp=1", split_line); end
        tick();
        ack_en = 1'b0;
        checks++; if (core_if.resume !== 1'b1 || core_if.split_active !== 1'b0) begin failures++; $display("FAIL basic_resume resume=%b active=%b exp=1/0", core_if.resume, core_if.split_active); end
        tick();
        checks++; if (core_if.resume !== 1'b0 || core_if.split_active !== 1'b0) begin failures++; $display("FAIL basic_resume_once resume=%b active=%b exp=0/0", core_if.resume, core_if.split_active); end
    endtask

    task automatic test_early_done();
        do_reset();
        core_if.split_req = 1'b1;
        core_if.core_done = 1'b1;
        tick();
        core_if.split_req = 1'b0;
        checks++; if (split_line !== 1'b1) begin failures++; $display("FAIL early_busy0 got=%b exp=1", split_line); end
        tick();
        checks++; if (split_line !== 1'b1) begin failures++; $display("FAIL early_busy1 got=%b exp=1", split_line); end
        tick();
        core_if.core_done = 1'b0;
        checks++; if (split_line !== 1'b0 || dut.drv_en_q !== 1'b1) begin failures++; $display("FAIL early_done line=%b drv=%b exp=0/1", split_line, dut.drv_en_q); end
        tick();
        tick();
        ack_en = 1'b1;
        tick();
        ack_en = 1'b0;
        checks++; if (core_if.resume !== 1'b1) begin failures++; $display("FAIL early_resume got=%b exp=1", core_if.resume); end
        tick();
    endtask

    task automatic test_timeout();
        do_reset();
        enter_wait_ack();
        checks++; if (dut.drv_en_q !== 1'b0) begin failures++; $display("FAIL to_released got=%b exp=0", dut.drv_en_q); end
        for (int i = 1; i < 8; i++) begin
            tick();
            checks++; if (core_if.split_err !== 1'b0 || core_if.split_active !== 1'b1) begin failures++; $display("FAIL to_wait[%0d] err=%b active=%b exp=0/1", i, core_if.split_err, core_if.split_active); end
        end
        tick();
        checks++; if (core_if.split_err !== 1'b1 || core_if.split_active !== 1'b0 || core_if.resume !== 1'b0) begin failures++; $display("FAIL to_fire err=%b active=%b resume=%b exp=1/0/0", core_if.split_err, core_if.split_active, core_if.resume); end
        tick();
        checks++; if (core_if.split_err !== 1'b0 || dut.drv_en_q !== 1'b0 || core_if.resume !== 1'b0) begin failures++; $display("FAIL to_after err=%b drv=%b resume=%b exp=0/0/0", core_if.split_err, dut.drv_en_q, core_if.resume); end
    endtask

    task automatic test_ack_priority();
        do_reset();
        enter_wait_ack();
        repeat (7) tick();
        ack_en = 1'b1;
        tick();
        ack_en = 1'b0;
        checks++; if (core_if.resume !== 1'b1 || core_if.split_err !== 1'b0) begin failures++; $display("FAIL prio_ack resume=%b err=%b exp=1/0", core_if.resume, core_if.split_err); end
        tick();
    endtask

    task automatic test_ignored_req();
        int n;
        do_reset();
        enter_wait_ack();
        tick();
        core_if.split_req = 1'b1;
        tick();
        core_if.split_req = 1'b0;
        checks++; if (core_if.split_active !== 1'b1 || dut.drv_en_q !== 1'b0) begin failures++; $display("FAIL ign_wait active=%b drv=%b exp=1/0", core_if.split_active, dut.drv_en_q); end
        ack_en = 1'b1;
        tick();
        ack_en = 1'b0;
        n = int'(core_if.resume);
        for (int i = 0; i < 3; i++) begin
            tick();
            n += int'(core_if.resume);
        end
        checks++; if (n != 1) begin failures++; $display("FAIL ign_resume_count got=%0d exp=1", n); end
        checks++; if (dut.drv_en_q !== 1'b0 || core_if.split_active !== 1'b0) begin failures++; $display("FAIL ign_no_queue drv=%b active=%b exp=0/0", dut.drv_en_q, core_if.split_active); end
    endtask

    task automatic test_reset_mid_split();
        do_reset();
        core_if.split_req = 1'b1;
        tick();
        core_if.split_req = 1'b0;
        checks++; if (split_line !== 1'b1) begin failures++; $display("FAIL rst_pre got=%b exp=1", split_line); end
        #3 rstn = 1'b0;
        #1;
        checks++; if (dut.drv_en_q !== 1'b0 || split_line !== 1'b0) begin failures++; $display("FAIL rst_async drv=%b line=%b exp=0/0", dut.drv_en_q, split_line); end
        checks++; if (core_if.split_active !== 1'b0 || core_if.resume !== 1'b0 || core_if.split_err !== 1'b0) begin failures++; $display("FAIL rst_outputs active=%b resume=%b err=%b exp=0/0/0", core_if.split_active, core_if.resume, core_if.split_err); end
        @(negedge clk);
        rstn = 1'b1;
        core_if.split_req = 1'b1;
        tick();
        core_if.split_req = 1'b0;
        checks++; if (split_line !== 1'b1 || core_if.split_active !== 1'b1) begin failures++; $display("FAIL rst_restart line=%b active=%b exp=1/1", split_line, core_if.split_active); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        enter_wait_ack();
        ack_en = 1'b1;
        tick();
        ack_en = 1'b0;
        core_if.split_req = 1'b1;
        tick();
        checks++; if (dut.drv_en_q !== 1'b0 || core_if.split_active !== 1'b0) begin failures++; $display("FAIL b2b_resume_ignores drv=%b active=%b exp=0/0", dut.drv_en_q, core_if.split_active); end
        tick();
        core_if.split_req = 1'b0;
        checks++; if (split_line !== 1'b1 || core_if.split_active !== 1'b1) begin failures++; $display("FAIL b2b_second line=%b active=%b exp=1/1", split_line, core_if.split_active); end
        core_if.core_done = 1'b1;
        tick();
        tick();
        core_if.core_done = 1'b0;
        checks++; if (split_line !== 1'b0) begin failures++; $display("FAIL b2b_second_done got=%b exp=0", split_line); end
    endtask

    initial begin
        core_if.split_req = 1'b0;
        core_if.core_done = 1'b0;
        test_reset();
        test_basic();
        test_early_done();
        test_timeout();
        test_ack_priority();
        test_ignored_req();
        test_reset_mid_split();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
